// File: rtl/shared_adder_scheduler.sv
// Two-requester scheduler around one shared nibble adder.
// Operands are summed LS nibble first, carry chained between passes.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'd0, cin};
endmodule

module shared_adder_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic             gnt0, gnt1;
  logic [IW+1:0]    sh;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_c;
  logic             last_nib;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign sh       = {idx_q, 2'b00};
  assign nib_a    = 4'(a_q >> sh);
  assign nib_b    = 4'(b_q >> sh);
  assign last_nib = (idx_q == IW'(NIB - 1));

  four_bit_adder u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_s),
    .cout (nib_c)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    id_d    = id_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          carry_d = gnt1 ? req1_cin : req0_cin;
          id_d    = gnt1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(WIDTH'(4'hF) << sh))
                | (WIDTH'(nib_s) << sh);
        carry_d = nib_c;
        idx_d   = idx_q + 1'b1;
        if (last_nib) begin
          cout_d  = nib_c;
          last_d  = id_q;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;
endmodule
